// File: rtl/priority_arbiter_pkg.sv
// Shared defaults and helpers for the priority arbiter.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package priority_arbiter_pkg;

    localparam int DEFAULT_NUM_REQUEST   = 3;
    localparam int DEFAULT_REQUEST_WIDTH = 64;

    // Index width that stays legal for a single-way build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/priority_arbiter_find_first_one.sv
// Lowest-index set bit finder: one-hot, binary index and any-set flag.
// Latency: combinational.
// Backpressure: n/a.
module find_first_one
    import priority_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_NUM_REQUEST,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [WIDTH-1:0] one_hot,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    always_comb begin
        one_hot = '0;
        index   = '0;
        found   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i] && !found) begin
                one_hot[i] = 1'b1;
                index      = IDX_W'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priority_arbiter.sv
// Critical-first / round-robin arbiter feeding a single-entry output register.
// Latency: one cycle from request valid (register empty) to request_valid_out.
// Backpressure: register holds until issue_ack_in; no grant while full or an ack pulse is out.
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int NUM_REQUEST                  = DEFAULT_NUM_REQUEST,
    parameter int SINGLE_REQUEST_WIDTH_IN_BITS = DEFAULT_REQUEST_WIDTH
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_REQUEST*SINGLE_REQUEST_WIDTH_IN_BITS-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]                              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]                              issue_ack_out,
    output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]             request_out,
    output logic                                                request_valid_out,
    input  logic                                                issue_ack_in
);

    localparam int W     = SINGLE_REQUEST_WIDTH_IN_BITS;
    localparam int N     = NUM_REQUEST;
    localparam int IDX_W = idx_width(NUM_REQUEST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] N_MOD    = IDX_W'(N);

    logic [IDX_W-1:0] rr_pointer;

    logic [N-1:0]     crit_vec;
    logic [N-1:0]     crit_oh;
    logic [IDX_W-1:0] crit_idx;
    logic             crit_found;

    logic [N-1:0]     rot_vec;
    logic [N-1:0]     rot_oh;
    logic [IDX_W-1:0] rot_idx;
    logic             rot_found;

    logic [N-1:0]     rr_oh;
    logic [IDX_W-1:0] rr_idx;
    logic [IDX_W-1:0] rr_sum;

    logic [N-1:0]     grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_rr;
    logic [W-1:0]     grant_dat;
    logic             grant_en;

    assign crit_vec = request_valid_flatted_in & request_critical_flatted_in;

    find_first_one #(.WIDTH(N)) u_crit_ffo (
        .vec     (crit_vec),
        .one_hot (crit_oh),
        .index   (crit_idx),
        .found   (crit_found)
    );

    // Rotate valids so that bit 0 is the way rr_pointer points at.
    always_comb begin
        rot_vec = '0;
        for (int i = 0; i < N; i++) begin
            if (i + int'(rr_pointer) < N) rot_vec[i] = request_valid_flatted_in[i + int'(rr_pointer)];
            else                          rot_vec[i] = request_valid_flatted_in[i + int'(rr_pointer) - N];
        end
    end

    find_first_one #(.WIDTH(N)) u_rr_ffo (
        .vec     (rot_vec),
        .one_hot (rot_oh),
        .index   (rot_idx),
        .found   (rot_found)
    );

    // Map the rotated pick back to an absolute way number.
    always_comb begin
        rr_oh  = '0;
        for (int i = 0; i < N; i++) begin
            if (i + int'(rr_pointer) < N) rr_oh[i + int'(rr_pointer)]     = rot_oh[i];
            else                          rr_oh[i + int'(rr_pointer) - N] = rot_oh[i];
        end
        rr_sum = rr_pointer + rot_idx;
        rr_idx = ((int'(rr_pointer) + int'(rot_idx)) >= N) ? rr_sum - N_MOD : rr_sum;
    end

    assign grant_oh  = crit_found ? crit_oh  : rr_oh;
    assign grant_idx = crit_found ? crit_idx : rr_idx;
    assign next_rr   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
    assign grant_en  = !request_valid_out && (issue_ack_out == '0) && rot_found;

    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_oh[i]) grant_dat = grant_dat | request_flatted_in[i*W +: W];
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rr_pointer        <= '0;
            issue_ack_out     <= '0;
            request_out       <= '0;
            request_valid_out <= 1'b0;
        end else begin
            issue_ack_out <= '0;
            if (grant_en) begin
                request_out       <= grant_dat;
                request_valid_out <= 1'b1;
                issue_ack_out     <= grant_oh;
                rr_pointer        <= next_rr;
            end else if (request_valid_out && issue_ack_in) begin
                request_out       <= '0;
                request_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_priority_arbiter.sv
// Bench for priority_arbiter: requester queues per way, consumer modes, scoreboard of grants.
module tb_priority_arbiter;

    localparam int N = 3;
    localparam int W = 64;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic [N*W-1:0] request_flatted_in;
    logic [N-1:0]   request_valid_flatted_in;
    logic [N-1:0]   request_critical_flatted_in;
    logic [N-1:0]   issue_ack_out;
    logic [W-1:0]   request_out;
    logic           request_valid_out;
    logic           issue_ack_in;

    priority_arbiter #(
        .NUM_REQUEST                  (N),
        .SINGLE_REQUEST_WIDTH_IN_BITS (W)
    ) dut (
        .clk_in                      (clk_in),
        .reset_in                    (reset_in),
        .request_flatted_in          (request_flatted_in),
        .request_valid_flatted_in    (request_valid_flatted_in),
        .request_critical_flatted_in (request_critical_flatted_in),
        .issue_ack_out               (issue_ack_out),
        .request_out                 (request_out),
        .request_valid_out           (request_valid_out),
        .issue_ack_in                (issue_ack_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed { logic [W-1:0] payload; logic crit; } item_t;
    typedef struct packed { logic [1:0] way; logic [W-1:0] payload; } exp_t;
    typedef struct { logic [N-1:0] valid; logic [N-1:0] crit; int exp_way; } vec_t;

    item_t way_q [N][$];
    exp_t  sb_q[$];
    int    ack_times[$];
    vec_t  tbl[13];

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           ack_mode = 1;   // 0 none, 1 ack next cycle, 2 every 20th valid cycle, 3 held high
    bit           flush_mode = 0;
    bit           record_acks = 0;
    int           vcnt = 0;
    bit           prev_vld = 0;
    bit           prev_ack_in = 0;
    logic [W-1:0] prev_dat = '0;
    logic [N-1:0] prev_iack = '0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input logic [1:0] w);
        return N'(1) << w;
    endfunction

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) if (way_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_req(input int way, input logic [W-1:0] p, input bit c);
        item_t it;
        it.payload = p;
        it.crit    = c;
        way_q[way].push_back(it);
    endtask

    task automatic expect_out(input int way, input logic [W-1:0] p);
        exp_t e;
        e.way     = 2'(way);
        e.payload = p;
        sb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        bit done;
        n = 0;
        done = 0;
        while (!done && n < budget) begin
            @(posedge clk_in); #1;
            n++;
            if (sb_q.size() == 0 && queues_empty() && !request_valid_out) done = 1;
        end
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout pending=%0d valid_out=%b", name, sb_q.size(), request_valid_out);
        end
    endtask

    // Monitor, consumer and requester model, all sampled away from the rising edge.
    always @(negedge clk_in) begin : mon
        exp_t e;
        if (!reset_in) begin
            prev_vld     = 0;
            prev_ack_in  = 0;
            prev_iack    = '0;
            vcnt         = 0;
            issue_ack_in = (ack_mode == 3);
        end else begin
            if (issue_ack_out != '0) begin
                check("ack_one_cycle", W'(prev_iack), '0);
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant actual ack=%b data=%h required no grant", issue_ack_out, request_out);
                end else begin
                    e = sb_q.pop_front();
                    check("grant_way", W'(issue_ack_out), W'(onehot(e.way)));
                    check("grant_payload", request_out, e.payload);
                    check("grant_valid", W'(request_valid_out), W'(1));
                end
                if (record_acks) ack_times.push_back(cyc);
            end
            if (prev_vld && !prev_ack_in) begin
                check("hold_valid", W'(request_valid_out), W'(1));
                check("hold_payload", request_out, prev_dat);
            end
            if (!request_valid_out) check("idle_payload_zero", request_out, '0);
            prev_vld  = request_valid_out;
            prev_dat  = request_out;
            prev_iack = issue_ack_out;

            case (ack_mode)
                1: issue_ack_in = request_valid_out;
                2: begin
                    issue_ack_in = 1'b0;
                    if (request_valid_out) begin
                        vcnt++;
                        if (vcnt == 20) begin
                            issue_ack_in = 1'b1;
                            vcnt = 0;
                        end
                    end
                end
                3: issue_ack_in = 1'b1;
                default: issue_ack_in = 1'b0;
            endcase
            prev_ack_in = issue_ack_in;

            for (int i = 0; i < N; i++)
                if (issue_ack_out[i] && way_q[i].size() > 0) void'(way_q[i].pop_front());
            if (flush_mode && issue_ack_out != '0)
                for (int i = 0; i < N; i++) way_q[i].delete();
        end
        for (int i = 0; i < N; i++) begin
            if (way_q[i].size() > 0) begin
                request_flatted_in[i*W +: W]   = way_q[i][0].payload;
                request_valid_flatted_in[i]    = 1'b1;
                request_critical_flatted_in[i] = way_q[i][0].crit;
            end else begin
                request_flatted_in[i*W +: W]   = '0;
                request_valid_flatted_in[i]    = 1'b0;
                request_critical_flatted_in[i] = 1'b0;
            end
        end
    end

    initial begin
        logic [W-1:0] p;
        bit           seen;

        // {valid, critical, expected way} applied in order; rr_pointer carries between rows.
        tbl[0]  = '{3'b111, 3'b000,  0};
        tbl[1]  = '{3'b111, 3'b000,  1};
        tbl[2]  = '{3'b111, 3'b000,  2};
        tbl[3]  = '{3'b110, 3'b000,  1};
        tbl[4]  = '{3'b011, 3'b000,  0};
        tbl[5]  = '{3'b111, 3'b100,  2};
        tbl[6]  = '{3'b111, 3'b110,  1};
        tbl[7]  = '{3'b101, 3'b000,  2};
        tbl[8]  = '{3'b010, 3'b101,  1};
        tbl[9]  = '{3'b001, 3'b001,  0};
        tbl[10] = '{3'b000, 3'b111, -1};
        tbl[11] = '{3'b101, 3'b000,  2};
        tbl[12] = '{3'b111, 3'b000,  0};

        reset_in                    = 1'b0;
        issue_ack_in                = 1'b0;
        request_flatted_in          = '0;
        request_valid_flatted_in    = '0;
        request_critical_flatted_in = '0;

        // Reset held with every way requesting.
        for (int i = 0; i < N; i++) push_req(i, 64'h1234_0000_0000_0000 | 64'(i), i == 0);
        repeat (5) begin
            @(posedge clk_in); #1;
            check("rst_valid_out", W'(request_valid_out), '0);
            check("rst_request_out", request_out, '0);
            check("rst_ack_out", W'(issue_ack_out), '0);
        end
        for (int i = 0; i < N; i++) way_q[i].delete();
        @(posedge clk_in); #1;
        reset_in = 1'b1;
        @(posedge clk_in); #1;

        // Single-grant table.
        flush_mode = 1;
        ack_mode   = 1;
        for (int v = 0; v < 13; v++) begin
            for (int i = 0; i < N; i++)
                if (tbl[v].valid[i]) push_req(i, 64'hA5A5_0000_0000_0000 | 64'(v*16 + i), tbl[v].crit[i]);
            if (tbl[v].exp_way >= 0) begin
                expect_out(tbl[v].exp_way, 64'hA5A5_0000_0000_0000 | 64'(v*16 + tbl[v].exp_way));
                wait_idle($sformatf("tbl%0d", v), 20);
            end else begin
                repeat (4) @(posedge clk_in);
                #1;
                check($sformatf("tbl%0d_no_grant", v), W'(request_valid_out), '0);
                for (int i = 0; i < N; i++) way_q[i].delete();
            end
        end
        flush_mode = 0;

        // 16 critical on way0, 16 non-critical on ways 1 and 2; fast then slow consumer.
        for (int pass = 0; pass < 2; pass++) begin
            ack_mode = (pass == 0) ? 1 : 2;
            for (int k = 0; k < 48; k++) push_req(k / 16, 64'hFFFF_FFFF_FFFF_FFFF - 64'(k), k < 16);
            for (int k = 0; k < 16; k++) expect_out(0, 64'hFFFF_FFFF_FFFF_FFFF - 64'(k));
            for (int k = 0; k < 16; k++) begin
                expect_out(1, 64'hFFFF_FFFF_FFFF_FFFF - 64'(16 + k));
                expect_out(2, 64'hFFFF_FFFF_FFFF_FFFF - 64'(32 + k));
            end
            wait_idle((pass == 0) ? "seq48_fast" : "seq48_slow", (pass == 0) ? 400 : 1500);
        end

        // Two critical ways outrank the lower-index non-critical one.
        ack_mode = 1;
        push_req(0, 64'hC0, 1'b0);
        push_req(1, 64'hC1, 1'b1);
        push_req(2, 64'hC2, 1'b1);
        expect_out(1, 64'hC1);
        expect_out(2, 64'hC2);
        expect_out(0, 64'hC0);
        wait_idle("crit_pair", 40);

        // Continuous consumer ack: one grant every two cycles.
        ack_mode    = 3;
        record_acks = 1;
        ack_times.delete();
        for (int k = 0; k < 6; k++) begin
            push_req(0, 64'hD000 + 64'(k), 1'b0);
            expect_out(0, 64'hD000 + 64'(k));
        end
        wait_idle("ack_held", 60);
        record_acks = 0;
        check("ack_held_count", W'(ack_times.size()), W'(6));
        for (int k = 1; k < ack_times.size(); k++)
            check($sformatf("ack_held_gap%0d", k), W'(ack_times[k] - ack_times[k-1]), W'(2));

        // Reset while a request is held, then round-robin restarts at way0.
        ack_mode = 0;
        push_req(1, 64'hE1, 1'b0);
        expect_out(1, 64'hE1);
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk_in); #1;
            if (request_valid_out) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL rst_mid_setup timeout actual valid_out=%b required 1", request_valid_out);
        end
        @(posedge clk_in); #1;
        reset_in = 1'b0;
        #1;
        check("rst_mid_valid", W'(request_valid_out), '0);
        check("rst_mid_data", request_out, '0);
        repeat (3) begin
            @(posedge clk_in); #1;
            check("rst_mid_ack", W'(issue_ack_out), '0);
        end
        reset_in   = 1'b1;
        flush_mode = 1;
        ack_mode   = 1;
        @(posedge clk_in); #1;
        for (int i = 0; i < N; i++) push_req(i, 64'hF0 + 64'(i), 1'b0);
        p = 64'hF0;
        expect_out(0, p);
        wait_idle("rst_rr_restart", 20);
        flush_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUEST, default 3, number of requester ways.
REQ-002 SHALL have parameter SINGLE_REQUEST_WIDTH_IN_BITS, default 64, payload width per way.
REQ-003 SHALL be one clock; reset is asynchronous and active-low.
REQ-004 clk_in  input  1  sole clock, rising edge.
REQ-005 reset_in  input  1  asynchronous active-low reset.
REQ-006 request_flatted_in  input  NUM_REQUEST*WIDTH  payloads; way i occupies bits [i*WIDTH +: WIDTH].
REQ-007 request_valid_flatted_in  input  NUM_REQUEST  per-way request valid.
REQ-008 request_critical_flatted_in  input  NUM_REQUEST  per-way critical flag, qualified by valid.
REQ-009 issue_ack_out  output  NUM_REQUEST  one-hot, one-cycle pulse telling way i its request was taken.
REQ-010 request_out  output  WIDTH  granted payload.
REQ-011 request_valid_out  output  1  request_out holds an unacknowledged request.
REQ-012 issue_ack_in  input  1  downstream consumed request_out this cycle.

Function
REQ-013 SHALL hold a single-entry output register (payload + valid) that drives request_out/request_valid_out directly.
REQ-014 Grant SHALL occur on a rising edge only when the output register is empty and issue_ack_out is all-zero in that cycle.
REQ-015 Critical class: if any way has valid&critical, SHALL grant the lowest-index such way (index 0 highest priority).
REQ-016 Non-critical class: otherwise SHALL grant round-robin among valid ways, searching upward from rr_pointer with wrap at NUM_REQUEST.
REQ-017 On every grant to way w (either class), rr_pointer SHALL become (w+1) mod NUM_REQUEST.
REQ-018 On the grant edge: output register loads way w payload, request_valid_out rises, issue_ack_out[w] asserts for exactly the following cycle only.
REQ-019 Latency SHALL be one cycle: request valid at edge k with empty register gives request_valid_out high after edge k.
REQ-020 request_out/request_valid_out SHALL remain stable until a rising edge with issue_ack_in=1, which empties the register.
REQ-021 issue_ack_in while request_valid_out=0 SHALL be ignored.
REQ-022 Next grant SHALL be no earlier than the edge after the emptying edge; issue_ack_in and grant are never simultaneous.
REQ-023 request_out SHALL read 0 while request_valid_out=0.
REQ-024 No valid inputs: no grant, rr_pointer unchanged.
REQ-025 Changes to a way's inputs while it holds issue_ack_out SHALL not affect the in-flight payload.

Reset
REQ-026 While reset_in=0: request_valid_out=0, request_out=0, issue_ack_out=0, rr_pointer=0, output register empty, asynchronously.
REQ-027 Reset mid-transaction SHALL discard the held request without issuing further acks.

Structure
REQ-028 Shared package SHALL hold default NUM_REQUEST and SINGLE_REQUEST_WIDTH_IN_BITS constants.
REQ-029 One sub-module find_first_one (lowest-index set bit, one-hot plus index outputs) SHALL serve both critical and rotated round-robin selection.

Verification
REQ-030 Reset: reset_in=0 with all inputs valid -> all outputs 0; no issue_ack_out pulses.
REQ-031 Way0 16 critical, ways1/2 16 non-critical each (payloads 0xFFFF_FFFF_FFFF_FFFF-i), consumer acks one cycle after valid -> 48 outputs; first 16 are way0 in order, then strictly alternating way1,way2 starting way1.
REQ-032 Same stimulus, consumer acks every 20th valid cycle -> identical order; request_out constant between acks; one issue_ack_out pulse per grant.
REQ-033 Ways1 and 2 both critical, way0 non-critical -> way1 granted first, then way2, then way0.
REQ-034 Single way valid, issue_ack_in held high continuously -> one grant per two cycles, issue_ack_out[0] one-cycle pulses, no duplicates.
REQ-035 reset_in pulsed low while request_valid_out=1 -> request_valid_out=0 immediately; rr_pointer=0 after release.
